// File: rtl/ulpi_rx_framer.sv
// ulpi_rx_framer: groups ULPI receive bytes into packets, buffers them and emits header+payload records.
// Define ULPI_RX_FRAMER_TIMESTAMP_EN to add a 16-bit receive timestamp to each record header.
module ulpi_rx_framer #(
  parameter int BUF_AW       = 11,
  parameter int HDR_DEPTH_AW = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IN_DATA,
  input  logic       IN_RXCMD,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       OUT_LAST,
  output logic [7:0] DROP_CNT
);

  localparam int DEPTH     = 1 << BUF_AW;
  localparam int HDR_DEPTH = 1 << HDR_DEPTH_AW;
  localparam logic [BUF_AW:0]       DEPTH_P  = {1'b1, {BUF_AW{1'b0}}};
  localparam logic [BUF_AW:0]       PTR_ONE  = {{BUF_AW{1'b0}}, 1'b1};
  localparam logic [BUF_AW:0]       PTR_ZERO = {(BUF_AW + 1){1'b0}};
  localparam logic [HDR_DEPTH_AW:0] HDR_FULL = {1'b1, {HDR_DEPTH_AW{1'b0}}};
  localparam logic [HDR_DEPTH_AW:0] HDR_ONE  = {{HDR_DEPTH_AW{1'b0}}, 1'b1};
  localparam logic [HDR_DEPTH_AW:0] HDR_ZERO = {(HDR_DEPTH_AW + 1){1'b0}};
`ifdef ULPI_RX_FRAMER_TIMESTAMP_EN
  localparam int         ENT_W    = 34;
  localparam logic [2:0] HDR_LAST = 3'd5;
`else
  localparam int         ENT_W    = 18;
  localparam logic [2:0] HDR_LAST = 3'd3;
`endif

  typedef enum logic {R_IDLE = 1'b0, R_ACTIVE = 1'b1} rx_state_e;
  typedef enum logic [1:0] {T_IDLE = 2'd0, T_HDR = 2'd1, T_PAY = 2'd2} tx_state_e;

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [1:0] flags,
                                          input logic [15:0] len, input logic [15:0] ts);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'hA0;
      3'd1:    b = {5'b00000, flags, 1'b0};
      3'd2:    b = len[7:0];
      3'd3:    b = len[15:8];
      3'd4:    b = ts[7:0];
      3'd5:    b = ts[15:8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;
  logic [BUF_AW:0] wr_ptr_q, wr_ptr_d, start_ptr_q, start_ptr_d;
  logic [BUF_AW:0] rd_ptr_q, rd_ptr_d, fetch_ptr_q, fetch_ptr_d, rd_addr_s, free_s;
  logic [15:0] len_q, len_d, rem_q, rem_d, cur_len_q, cur_len_d, cur_ts_s;
  logic err_q, err_d, trunc_q, trunc_d, in_ready_q;
  logic [1:0] cur_flags_q, cur_flags_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [7:0] mem [DEPTH];
  logic [7:0] ram_dout_q;
  logic mem_we_s, hdr_push_s, hdr_pop_s, take_s, load_s;
  logic [ENT_W-1:0] hdr_mem_q [HDR_DEPTH];
  logic [ENT_W-1:0] hdr_entry_s, hdr_head_s;
  logic [HDR_DEPTH_AW-1:0] hdr_wp_q, hdr_rp_q;
  logic [HDR_DEPTH_AW:0] hdr_cnt_q, hdr_cnt_d;
  logic [2:0] hdr_idx_q, hdr_idx_d;
  logic [7:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic out_pay_q, out_pay_d, out_first_q, out_first_d;
  logic unused_s;
`ifdef ULPI_RX_FRAMER_TIMESTAMP_EN
  logic [15:0] ts_cnt_q, ts_q, ts_d, cur_ts_q, cur_ts_d;
  assign hdr_entry_s = {err_q, trunc_q, len_q, ts_q};
  assign cur_ts_s    = cur_ts_q;
`else
  assign hdr_entry_s = {err_q, trunc_q, len_q};
  assign cur_ts_s    = 16'h0000;
`endif

  assign free_s     = DEPTH_P - (wr_ptr_q - rd_ptr_q);
  assign hdr_head_s = hdr_mem_q[hdr_rp_q];
  assign take_s     = out_valid_q && OUT_READY;
  assign load_s     = !out_valid_q || OUT_READY;
  // The header entry stays queued until its first byte is accepted, so a stalled sink backs up the FIFO.
  assign hdr_pop_s  = take_s && out_first_q;
  assign unused_s   = ^{IN_DATA[7:6], IN_DATA[3:0], rd_addr_s[BUF_AW]};

  assign IN_READY  = in_ready_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;
  assign DROP_CNT  = drop_cnt_q;

  // Receive framing: payload capture, truncation, error flag and commit/rollback.
  always_comb begin
    rx_state_d  = rx_state_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    len_d       = len_q;
    err_d       = err_q;
    trunc_d     = trunc_q;
    drop_cnt_d  = drop_cnt_q;
    mem_we_s    = 1'b0;
    hdr_push_s  = 1'b0;
`ifdef ULPI_RX_FRAMER_TIMESTAMP_EN
    ts_d        = ts_q;
`endif
    if (IN_VALID) begin
      case (rx_state_q)
        R_IDLE: begin
          if (IN_RXCMD && IN_DATA[4]) begin
            rx_state_d  = R_ACTIVE;
            start_ptr_d = wr_ptr_q;
            len_d       = 16'd0;
            err_d       = 1'b0;
            trunc_d     = 1'b0;
`ifdef ULPI_RX_FRAMER_TIMESTAMP_EN
            ts_d        = ts_cnt_q;
`endif
          end else begin
            rx_state_d = R_IDLE;
          end
        end
        R_ACTIVE: begin
          if (!IN_RXCMD) begin
            if (free_s != PTR_ZERO) begin
              mem_we_s = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_ONE;
              len_d    = len_q + 16'd1;
            end else begin
              trunc_d = 1'b1;
            end
          end else if (!IN_DATA[4]) begin
            rx_state_d = R_IDLE;
            if (hdr_cnt_q != HDR_FULL) begin
              hdr_push_s = 1'b1;
            end else begin
              wr_ptr_d   = start_ptr_q;
              drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
            end
          end else if (IN_DATA[5]) begin
            err_d = 1'b1;
          end else begin
            rx_state_d = R_ACTIVE;
          end
        end
        default: rx_state_d = R_IDLE;
      endcase
    end else begin
      rx_state_d = rx_state_q;
    end
  end

  // Transmit sequencing: header bytes, then payload from the prefetched RAM word.
  always_comb begin
    tx_state_d  = tx_state_q;
    rd_ptr_d    = rd_ptr_q;
    fetch_ptr_d = fetch_ptr_q;
    rd_addr_s   = fetch_ptr_q;
    rem_d       = rem_q;
    cur_len_d   = cur_len_q;
    cur_flags_d = cur_flags_q;
    hdr_idx_d   = hdr_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !OUT_READY;
    out_last_d  = out_last_q;
    out_pay_d   = out_pay_q;
    out_first_d = out_first_q;
`ifdef ULPI_RX_FRAMER_TIMESTAMP_EN
    cur_ts_d    = cur_ts_q;
`endif
    if (take_s && out_pay_q) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case (tx_state_q)
      T_IDLE: begin
        if (hdr_cnt_q != HDR_ZERO) begin
          cur_flags_d = hdr_head_s[ENT_W-1 -: 2];
          cur_len_d   = hdr_head_s[ENT_W-3 -: 16];
          rem_d       = hdr_head_s[ENT_W-3 -: 16];
`ifdef ULPI_RX_FRAMER_TIMESTAMP_EN
          cur_ts_d    = hdr_head_s[15:0];
`endif
          hdr_idx_d   = 3'd0;
          tx_state_d  = T_HDR;
        end else begin
          tx_state_d = T_IDLE;
        end
      end
      T_HDR: begin
        if (load_s) begin
          out_data_d  = hdr_byte(hdr_idx_q, cur_flags_q, cur_len_q, cur_ts_s);
          out_valid_d = 1'b1;
          out_pay_d   = 1'b0;
          out_first_d = (hdr_idx_q == 3'd0);
          out_last_d  = (hdr_idx_q == HDR_LAST) && (cur_len_q == 16'd0);
          hdr_idx_d   = hdr_idx_q + 3'd1;
          if (hdr_idx_q == HDR_LAST) begin
            tx_state_d = (cur_len_q == 16'd0) ? T_IDLE : T_PAY;
          end else begin
            tx_state_d = T_HDR;
          end
        end else begin
          tx_state_d = T_HDR;
        end
      end
      T_PAY: begin
        if (load_s) begin
          out_data_d  = ram_dout_q;
          out_valid_d = 1'b1;
          out_pay_d   = 1'b1;
          out_first_d = 1'b0;
          out_last_d  = (rem_q == 16'd1);
          rem_d       = rem_q - 16'd1;
          fetch_ptr_d = fetch_ptr_q + PTR_ONE;
          rd_addr_s   = fetch_ptr_q + PTR_ONE;
          tx_state_d  = (rem_q == 16'd1) ? T_IDLE : T_PAY;
        end else begin
          tx_state_d = T_PAY;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // Header FIFO occupancy.
  always_comb begin
    case ({hdr_push_s, hdr_pop_s})
      2'b10:   hdr_cnt_d = hdr_cnt_q + HDR_ONE;
      2'b01:   hdr_cnt_d = hdr_cnt_q - HDR_ONE;
      default: hdr_cnt_d = hdr_cnt_q;
    endcase
  end

  // Payload RAM; the read port tracks the next byte to present so payload streams at one byte per cycle.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem[wr_ptr_q[BUF_AW-1:0]] <= IN_DATA;
    end
    ram_dout_q <= mem[rd_addr_s[BUF_AW-1:0]];
  end

  // State registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state_q  <= R_IDLE;
      tx_state_q  <= T_IDLE;
      wr_ptr_q    <= PTR_ZERO;
      start_ptr_q <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      fetch_ptr_q <= PTR_ZERO;
      len_q       <= 16'd0;
      rem_q       <= 16'd0;
      cur_len_q   <= 16'd0;
      cur_flags_q <= 2'b00;
      err_q       <= 1'b0;
      trunc_q     <= 1'b0;
      drop_cnt_q  <= 8'd0;
      in_ready_q  <= 1'b0;
      hdr_wp_q    <= {HDR_DEPTH_AW{1'b0}};
      hdr_rp_q    <= {HDR_DEPTH_AW{1'b0}};
      hdr_cnt_q   <= HDR_ZERO;
      hdr_idx_q   <= 3'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pay_q   <= 1'b0;
      out_first_q <= 1'b0;
      for (int i = 0; i < HDR_DEPTH; i++) begin
        hdr_mem_q[i] <= {ENT_W{1'b0}};
      end
`ifdef ULPI_RX_FRAMER_TIMESTAMP_EN
      ts_cnt_q    <= 16'd0;
      ts_q        <= 16'd0;
      cur_ts_q    <= 16'd0;
`endif
    end else begin
      rx_state_q  <= rx_state_d;
      tx_state_q  <= tx_state_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fetch_ptr_q <= fetch_ptr_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      cur_len_q   <= cur_len_d;
      cur_flags_q <= cur_flags_d;
      err_q       <= err_d;
      trunc_q     <= trunc_d;
      drop_cnt_q  <= drop_cnt_d;
      in_ready_q  <= 1'b1;
      hdr_cnt_q   <= hdr_cnt_d;
      hdr_idx_q   <= hdr_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_pay_q   <= out_pay_d;
      out_first_q <= out_first_d;
      if (hdr_push_s) begin
        hdr_mem_q[hdr_wp_q] <= hdr_entry_s;
        hdr_wp_q            <= hdr_wp_q + {{(HDR_DEPTH_AW-1){1'b0}}, 1'b1};
      end
      if (hdr_pop_s) begin
        hdr_rp_q <= hdr_rp_q + {{(HDR_DEPTH_AW-1){1'b0}}, 1'b1};
      end
`ifdef ULPI_RX_FRAMER_TIMESTAMP_EN
      ts_cnt_q    <= ts_cnt_q + 16'd1;
      ts_q        <= ts_d;
      cur_ts_q    <= cur_ts_d;
`endif
    end
  end

endmodule

// File: doc/ulpi_rx_framer.md
Name: ulpi_rx_framer

Overview:
- Downstream consumer of the ULPI PHY interface stage's receive stream (DATA/RXCMD/VALID).
- Groups bytes between RxActive assert/deassert into USB packets, buffers payload, and emits each packet to the host-side byte stream with a header.
- Drops and counts packets it cannot store; the upstream stage is never stalled.

Parameters:
BUF_AW, 11, payload RAM address width; depth = 2^BUF_AW bytes
HDR_DEPTH_AW, 2, header FIFO address width; 4 committed packets

Ports:
CLK  input  1  system clock (DATA_CLK domain of the ULPI stage)
RST  input  1  asynchronous, active-high reset
IN_DATA  input  8  byte from ULPI stage
IN_RXCMD  input  1  IN_DATA is an RX CMD byte, not payload
IN_VALID  input  1  IN_DATA/IN_RXCMD valid this cycle
IN_READY  output  1  wired to the ULPI stage's READY input
OUT_DATA  output  8  host stream byte
OUT_VALID  output  1  OUT_DATA valid
OUT_READY  input  1  host sink accepts byte
OUT_LAST  output  1  final byte of current record
DROP_CNT  output  8  dropped-packet count, saturating

Behaviour:
- Reset (asynchronous) clears all of the following: pointers, FSMs, header FIFO, timestamp, flags, DROP_CNT=0, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, IN_READY=0.
- IN_READY=1 every cycle after reset releases. Input bytes are accepted whenever IN_VALID=1.
- RX CMD decode: IN_DATA[4] is RxActive; IN_DATA[5:4]==2'b11 is RxError.
- RX FSM states: R_IDLE, R_ACTIVE.
  - R_IDLE -> R_ACTIVE on a valid RXCMD with bit4=1. On entry: start_ptr<=wr_ptr, len<=0, flags<=0, ts latched.
  - R_IDLE ignores data bytes and RXCMDs with bit4=0.
  - In R_ACTIVE, a valid non-RXCMD byte writes RAM[wr_ptr] and increments wr_ptr and len, provided free space > 0.
  - If free space is 0, the byte is discarded, TRUNC is set, and len is not incremented.
  - A valid RXCMD with [5:4]==11 sets ERR and stays in R_ACTIVE.
  - R_ACTIVE -> R_IDLE on a valid RXCMD with bit4=0. This is the commit.
- Commit:
  - If the header FIFO is not full, push {flags, len[15:0], ts}. wr_ptr keeps its value.
  - If the header FIFO is full, wr_ptr<=start_ptr (rollback), DROP_CNT++ saturating at 255, and the packet is lost.
  - "Full" is evaluated on the registered count at the start of the cycle. A same-cycle pop does not rescue the packet.
- Pointer and length arithmetic:
  - Pointers are BUF_AW+1 bits. free = 2^BUF_AW - (wr_ptr - rd_ptr), where rd_ptr is the committed-read pointer.
  - len is 16 bits. Its maximum is 2^BUF_AW, so it never wraps.
- Zero-length packets (RxActive pulse with no data) are committed and emitted with len=0.
- TX FSM states: T_IDLE, T_HDR, T_PAY.
  - T_IDLE pops a header entry when the FIFO is non-empty and moves to T_HDR.
  - T_HDR emits header bytes in order:
    1. 0xA0
    2. {5'b0, ERR, TRUNC, 1'b0}
    3. len[7:0]
    4. len[15:8]
    5. optional timestamp bytes (see below)
  - T_PAY emits len bytes from RAM starting at the committed rd_ptr. rd_ptr increments per accepted payload byte.
  - OUT_LAST is asserted on the last payload byte, or on the last header byte if len==0.
- Output handshake:
  - A byte transfers when OUT_VALID & OUT_READY.
  - OUT_DATA/OUT_LAST are held stable while OUT_VALID & !OUT_READY.
  - Back-to-back bytes are allowed, so one byte per cycle is sustained. A RAM read prefetch or skid register is required to hide synchronous-read latency.
- TX only ever sees committed data; RX and TX run concurrently.
- Reset mid-packet: all buffered and partial data is lost and nothing is emitted afterwards.

Optional Feature:
- ULPI_RX_FRAMER_TIMESTAMP_EN defined:
  - A 16-bit free-running counter increments every CLK and wraps at 0xFFFF.
  - Its value is latched on the R_IDLE->R_ACTIVE transition and stored in the header entry.
  - The header is 6 bytes: after len[15:8], append ts[7:0] then ts[15:8].
- Not defined: no counter and no ts storage; the header is 4 bytes.

Test Plan:
- RXCMD 0x10, data 0x2D 0x00 0x10, RXCMD 0x00 -> output A0 00 03 00 [ts lo, ts hi] 2D 00 10, with OUT_LAST on 0x10.
- RXCMD 0x10 then RXCMD 0x00, no data -> A0 00 00 00 [ts], with OUT_LAST on the final header byte.
- Packet containing RXCMD 0x30 mid-payload, 2 data bytes -> flags byte 0x04, len 0x0002.
- OUT_READY=0, five 1-byte packets sent:
  - Packets 1-4 commit; packet 5 is dropped and DROP_CNT=1.
  - Raising OUT_READY yields exactly 4 records, identical in content.
- BUF_AW=4, 20-byte packet -> len=0x0010, flags 0x02, first 16 bytes emitted intact.
- OUT_READY toggling 1/0 every cycle during payload -> no byte is duplicated or skipped, and OUT_DATA is stable while stalled.
